// File: rtl/bram_c_readback.sv
// Streams result rows of matrix C out of the single-port output BRAM onto a valid/ready stream.
// Optional clear-on-read (zero each row after reading it) is enabled by defining READBACK_CLEAR_EN.
module bram_c_readback #(
    parameter int AWIDTH      = 10,
    parameter int DWIDTH      = 8,
    parameter int ROW_ELEMS   = 4,
    parameter int ADDR_STRIDE = 4,
    parameter int MASK_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [AWIDTH-1:0]             base_addr,
    input  logic [7:0]                    num_rows,
    output logic                          busy,
    output logic                          done,
    output logic [AWIDTH-1:0]             bram_addr,
    output logic                          bram_en,
    input  logic [ROW_ELEMS*DWIDTH-1:0]   bram_rdata,
    output logic [MASK_WIDTH-1:0]         bram_we,
    output logic [ROW_ELEMS*DWIDTH-1:0]   bram_wdata,
    output logic [ROW_ELEMS*DWIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last
);

    localparam int RW = ROW_ELEMS * DWIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t            r_state;
    logic [AWIDTH-1:0] r_addr;
    logic [7:0]        r_num_rows;
    logic [7:0]        r_issued;
    logic [7:0]        r_beats;
    logic              r_rd_pend;
    logic [1:0]        r_count;
    logic              r_wptr;
    logic              r_rptr;
    logic [RW-1:0]     r_buf [2];

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_pending;
    logic              w_issue;
    logic              w_last_read;

`ifdef READBACK_CLEAR_EN
    logic              r_clr_pend;
    logic [AWIDTH-1:0] r_clr_addr;
`endif

    assign w_pop  = out_valid && out_ready;
    assign w_push = r_rd_pend;

    // Occupancy after this edge: counting the beat leaving this cycle lets
    // a new read issue every cycle while the buffer can never exceed two rows.
    assign w_pending = 3'(r_count) + 3'(r_rd_pend) - 3'(w_pop);

`ifdef READBACK_CLEAR_EN
    assign w_issue    = (r_state == S_READ) && (w_pending < 3'd2) && !r_clr_pend;
    assign bram_en    = w_issue || r_clr_pend;
    assign bram_addr  = r_clr_pend ? r_clr_addr : r_addr;
    assign bram_we    = r_clr_pend ? {MASK_WIDTH{1'b1}} : {MASK_WIDTH{1'b0}};
`else
    assign w_issue    = (r_state == S_READ) && (w_pending < 3'd2);
    assign bram_en    = w_issue;
    assign bram_addr  = r_addr;
    assign bram_we    = {MASK_WIDTH{1'b0}};
`endif

    assign bram_wdata  = {RW{1'b0}};
    assign w_last_read = (r_issued == r_num_rows - 8'd1);

    assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done      = (r_state == S_FINISH);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_buf[r_rptr];
    assign out_last  = out_valid && (r_beats == r_num_rows - 8'd1);

    // NOTE: state uses non-blocking assignments so every update in this block sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_num_rows <= '0;
            r_issued   <= '0;
            r_beats    <= '0;
            r_rd_pend  <= 1'b0;
            r_count    <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            // NOTE: the buffer words are reset so out_data reads 0 out of reset rather than X.
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
`ifdef READBACK_CLEAR_EN
            r_clr_pend <= 1'b0;
            r_clr_addr <= '0;
`endif
        end else begin
            if (w_push) begin
                r_buf[r_wptr] <= bram_rdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr  <= ~r_rptr;
                r_beats <= r_beats + 8'd1;
            end
            r_count   <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_rd_pend <= w_issue;
`ifdef READBACK_CLEAR_EN
            r_clr_pend <= w_issue;
            if (w_issue) r_clr_addr <= r_addr;
`endif
            if (w_issue) begin
                r_addr   <= r_addr + AWIDTH'(ADDR_STRIDE);
                r_issued <= r_issued + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (num_rows != 8'd0) begin
                            r_state    <= S_READ;
                            r_addr     <= base_addr;
                            r_num_rows <= num_rows;
                            r_issued   <= '0;
                            r_beats    <= '0;
                        end else begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue && w_last_read) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop && out_last) r_state <= S_FINISH;
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_c_readback.sv
// Self-checking bench for bram_c_readback: BRAM model, scoreboard of expected addresses/rows,
// table of transfers with different backpressure patterns, plus reset and clear-on-read sequences.
module tb_bram_c_readback;

    localparam int AW     = 10;
    localparam int RW     = 32;
    localparam int STRIDE = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [7:0]    num_rows;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [RW-1:0] bram_rdata;
    logic [3:0]    bram_we;
    logic [RW-1:0] bram_wdata;
    logic [RW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;

    bram_c_readback #(
        .AWIDTH(AW), .DWIDTH(8), .ROW_ELEMS(4), .ADDR_STRIDE(STRIDE), .MASK_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en),
        .bram_rdata(bram_rdata), .bram_we(bram_we), .bram_wdata(bram_wdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] init_word(input int a);
        case (a)
            0:       return 32'h11111111;
            4:       return 32'h22222222;
            8:       return 32'h33333333;
            12:      return 32'h44444444;
            default: return 32'hA5000000 | 32'(a);
        endcase
    endfunction

    // Single-port BRAM model, one-cycle read latency; loaded once while reset is first held.
    logic [RW-1:0] ram [1024];
    logic          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int a = 0; a < 1024; a++) ram[a] <= init_word(a);
            ram_loaded <= 1'b1;
        end else if (bram_en) begin
            if (bram_we == 4'hF) ram[bram_addr] <= bram_wdata;
            else                 bram_rdata     <= ram[bram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int rdy_mode = 0;
    int ph_base  = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = ((cyc - ph_base) % 3 == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [RW-1:0] exp_mem [1024];
    logic [RW-1:0] q_data [$];
    logic [AW-1:0] q_addr [$];
    int            cur_num, tb_issued, tb_beats, start_cyc;
    int            first_valid_cyc, first_read_cyc, last_hs_cyc, done_cyc, done_count;
    logic          mon_en = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_read = 1'b0;
    logic          prev_last;
    logic [RW-1:0] prev_data;
    logic [AW-1:0] last_rd_addr = '0;

    // Monitor: samples mid-cycle; a handshake/read seen here completes at the next rising edge.
    always @(negedge clk) begin
        logic rd, wr, hs;
        if (reset && mon_en) begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", out_data, prev_data);
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;

            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("done_busy_low", 32'(busy), 32'd0);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

            wr = bram_en && (bram_we != 4'h0);
            rd = bram_en && (bram_we == 4'h0);
            if (wr) begin
`ifdef READBACK_CLEAR_EN
                check("clr_we", 32'(bram_we), 32'hF);
                check("clr_wdata", bram_wdata, 32'h0);
                check("clr_addr", 32'(bram_addr), 32'(last_rd_addr));
                check("clr_after_read", 32'(prev_read), 32'd1);
`else
                check("we_zero", 32'(bram_we), 32'h0);
`endif
            end
            if (rd) begin
                if (first_read_cyc < 0) first_read_cyc = cyc;
                check("reads_left", 32'(q_addr.size() != 0), 32'd1);
                if (q_addr.size() != 0) check("read_addr", 32'(bram_addr), 32'(q_addr.pop_front()));
                check("wdata_zero", bram_wdata, 32'h0);
`ifdef READBACK_CLEAR_EN
                check("clr_read_spacing", 32'(prev_read), 32'd0);
`endif
                last_rd_addr = bram_addr;
            end

            hs = out_valid && out_ready;
            if (hs) begin
                check("beats_left", 32'(q_data.size() != 0), 32'd1);
                if (q_data.size() != 0) check("beat_data", out_data, q_data.pop_front());
                check("beat_last", 32'(out_last), 32'(tb_beats == cur_num - 1));
                tb_beats++;
                last_hs_cyc = cyc;
            end
            if (rd) begin
                tb_issued++;
                check("outstanding_le2", 32'((tb_issued - tb_beats) <= 2), 32'd1);
            end
            prev_read = rd;
        end else begin
            prev_stall = 1'b0;
            prev_read  = 1'b0;
        end
    end

    task automatic start_transfer(input logic [AW-1:0] b, input logic [7:0] n, input int mode);
        logic [AW-1:0] a;
        rdy_mode = mode;
        @(posedge clk);
        #2;
        start = 1'b1;
        base_addr = b;
        num_rows  = n;
        q_data.delete();
        q_addr.delete();
        tb_issued = 0; tb_beats = 0; cur_num = int'(n);
        first_valid_cyc = -1; first_read_cyc = -1; last_hs_cyc = -1;
        done_cyc = -1; done_count = 0;
        start_cyc = cyc;
        ph_base   = cyc + 1;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i * STRIDE);
            q_addr.push_back(a);
            q_data.push_back(exp_mem[a]);
`ifdef READBACK_CLEAR_EN
            exp_mem[a] = '0;
`endif
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        base_addr = '0;
        num_rows  = '0;
    endtask

    task automatic run_transfer(input logic [AW-1:0] b, input logic [7:0] n, input int mode,
                                input string tag);
        start_transfer(b, n, mode);
        for (int k = 0; k < 400 && done_count == 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_done_once"}, 32'(done_count), 32'd1);
        check({tag, "_beats"}, 32'(tb_beats), 32'(n));
        check({tag, "_reads"}, 32'(tb_issued), 32'(n));
        check({tag, "_rows_pending"}, 32'(q_data.size()), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        if (n == 8'd0) begin
            check({tag, "_done_cycle"}, 32'(done_cyc), 32'(start_cyc + 1));
            check({tag, "_no_valid"}, 32'(first_valid_cyc), 32'hFFFFFFFF);
        end else begin
            check({tag, "_done_cycle"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
        end
`ifndef READBACK_CLEAR_EN
        if (mode == 0 && n != 8'd0) begin
            check({tag, "_first_read"}, 32'(first_read_cyc), 32'(start_cyc + 1));
            check({tag, "_first_valid"}, 32'(first_valid_cyc), 32'(start_cyc + 3));
            check({tag, "_latency"}, 32'(last_hs_cyc - start_cyc), 32'(int'(n) + 2));
        end
`endif
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [7:0]    num;
        int            mode;
        string         tag;
    } vec_t;

    vec_t vecs [6];

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
        check({tag, "_bram_en"}, 32'(bram_en), 32'd0);
        check({tag, "_bram_we"}, 32'(bram_we), 32'd0);
        check({tag, "_bram_wdata"}, bram_wdata, 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
    endtask

    initial begin
        vecs[0] = '{base: 10'd0,    num: 8'd4, mode: 0, tag: "seq4"};
        vecs[1] = '{base: 10'd0,    num: 8'd4, mode: 1, tag: "stall4"};
        vecs[2] = '{base: 10'd1020, num: 8'd2, mode: 0, tag: "wrap2"};
        vecs[3] = '{base: 10'd0,    num: 8'd0, mode: 0, tag: "zero"};
        vecs[4] = '{base: 10'd100,  num: 8'd7, mode: 2, tag: "rand7"};
        vecs[5] = '{base: 10'd1016, num: 8'd5, mode: 1, tag: "wrapstall5"};

        for (int a = 0; a < 1024; a++) exp_mem[a] = init_word(a);

        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) run_transfer(vecs[i].base, vecs[i].num, vecs[i].mode, vecs[i].tag);

        // Reset while the second beat is on the bus.
        start_transfer(10'd0, 8'd4, 0);
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #2;
            if (tb_beats == 1 && out_valid) break;
        end
        check("rst_reached_beat2", 32'(tb_beats), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        q_data.delete();
        q_addr.delete();
        done_count = 0;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("rst_no_done", 32'(done_count), 32'd0);
        run_transfer(10'd200, 8'd1, 0, "after_rst");

`ifdef READBACK_CLEAR_EN
        run_transfer(10'd40, 8'd4, 0, "clr_first");
        run_transfer(10'd40, 8'd4, 0, "clr_second");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
